// File: rtl/axi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_pkg                                                      |
// | Description : AXI burst/response codes and the dmem slave state encoding.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package axi_pkg;

   localparam logic [1:0] c_burst_fixed = 2'b00;
   localparam logic [1:0] c_burst_incr  = 2'b01;
   localparam logic [1:0] c_burst_wrap  = 2'b10;

   localparam logic [1:0] c_resp_okay   = 2'b00;
   localparam logic [1:0] c_resp_exokay = 2'b01;
   localparam logic [1:0] c_resp_slverr = 2'b10;
   localparam logic [1:0] c_resp_decerr = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WDATA = 2'd1,
      S_WRESP = 2'd2,
      S_RDATA = 2'd3
   } slave_state_t;

   // WRAP and the reserved code advance like INCR; only FIXED holds the address.
   function automatic logic is_fixed(input logic [1:0] burst);
      return burst == c_burst_fixed;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_array                                                   |
// | Description : DEPTH_WORDS x 32 storage, byte write enables, async read.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dmem_array #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic [3:0]                     i_we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] i_waddr,
   input  logic [31:0]                    i_wdata,
   input  logic [$clog2(DEPTH_WORDS)-1:0] i_raddr,
   output logic [31:0]                    o_rdata
);

   for (genvar g = 0; g < 4; g++) begin : g_lane
      logic [7:0] r_lane [DEPTH_WORDS];

      always_ff @(posedge clk) begin
         if (i_we[g]) r_lane[i_waddr] <= i_wdata[8*g +: 8];
      end

      assign o_rdata[8*g +: 8] = r_lane[i_raddr];
   end

endmodule
`default_nettype wire

// File: rtl/axi_dmem_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_dmem_slave                                               |
// | Description : Single-outstanding AXI4 slave over a word-addressed memory.  |
// |               Define DMEM_ADDR_CHECK_EN to reject out-of-range beats.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axi_dmem_slave
   import axi_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic [1:0]        awburst,
   input  logic [7:0]        awlen,
   input  logic [2:0]        awsize,
   input  logic [3:0]        awcache,
   input  logic              awvalid,
   output logic              awready,
   input  logic [31:0]       wdata,
   input  logic [3:0]        wstrb,
   input  logic              wlast,
   input  logic              wvalid,
   output logic              wready,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready,
   input  logic [ADDR_W-1:0] araddr,
   input  logic [1:0]        arburst,
   input  logic [7:0]        arlen,
   input  logic [2:0]        arsize,
   input  logic [3:0]        arcache,
   input  logic              arvalid,
   output logic              arready,
   output logic [31:0]       rdata,
   output logic [1:0]        rresp,
   output logic              rlast,
   output logic              rvalid,
   input  logic              rready
);

   localparam int c_aw = $clog2(DEPTH_WORDS);
   localparam int c_iw = ADDR_W - 2;
`ifdef DMEM_ADDR_CHECK_EN
   localparam bit c_addr_check = 1'b1;
`else
   localparam bit c_addr_check = 1'b0;
`endif

   slave_state_t    r_state, w_state_nxt;
   logic [c_iw-1:0] r_idx, w_idx_nxt, w_rd_idx;
   logic [7:0]      r_len, r_beat;
   logic            r_fixed, r_err, r_rlast;
   logic [31:0]     r_rdata, w_mem_rdata;
   logic [1:0]      r_rresp, r_bresp;
   logic            w_aw_hs, w_ar_hs, w_w_hs, w_r_hs;
   logic            w_last_beat, w_rd_oob, w_wr_oob, w_wlast_bad;
   logic [3:0]      w_we;
   logic            w_unused_ok;

   // The index is kept unwrapped so range checking can see overflow past the array.
   assign w_idx_nxt   = r_fixed ? r_idx : r_idx + c_iw'(1);
   assign w_rd_idx    = (r_state == S_IDLE) ? araddr[ADDR_W-1:2] : w_idx_nxt;
   assign w_last_beat = (r_beat == r_len);
   assign w_rd_oob    = c_addr_check && ((w_rd_idx >> c_aw) != '0);
   assign w_wr_oob    = c_addr_check && ((r_idx >> c_aw) != '0);
   assign w_wlast_bad = (wlast != w_last_beat);

   assign w_aw_hs = awvalid && awready;
   assign w_ar_hs = arvalid && arready;
   assign w_w_hs  = wvalid && wready;
   assign w_r_hs  = rvalid && rready;
   assign w_we    = (w_w_hs && !w_wr_oob) ? wstrb : 4'b0000;

   assign rdata = r_rdata;
   assign rresp = r_rresp;
   assign rlast = r_rlast;
   assign bresp = r_bresp;

   assign w_unused_ok = ^{awsize, awcache, arsize, arcache, awaddr[1:0], araddr[1:0]};

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      awready     = 1'b0;
      arready     = 1'b0;
      wready      = 1'b0;
      bvalid      = 1'b0;
      rvalid      = 1'b0;
      if (rst_n) begin
         case (r_state)
            S_IDLE: begin
               awready = 1'b1;
               arready = !awvalid;
               if (awvalid)      w_state_nxt = S_WDATA;
               else if (arvalid) w_state_nxt = S_RDATA;
            end
            S_WDATA: begin
               wready = 1'b1;
               if (wvalid && w_last_beat) w_state_nxt = S_WRESP;
            end
            S_WRESP: begin
               bvalid = 1'b1;
               if (bready) w_state_nxt = S_IDLE;
            end
            S_RDATA: begin
               rvalid = 1'b1;
               if (rready && w_last_beat) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_idx   <= '0;
         r_len   <= '0;
         r_beat  <= '0;
         r_fixed <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
         r_rresp <= c_resp_okay;
         r_rlast <= 1'b0;
         r_bresp <= c_resp_okay;
      end else begin
         if (w_aw_hs || w_ar_hs) begin
            r_idx   <= w_aw_hs ? awaddr[ADDR_W-1:2] : araddr[ADDR_W-1:2];
            r_len   <= w_aw_hs ? awlen : arlen;
            r_fixed <= is_fixed(w_aw_hs ? awburst : arburst);
            r_beat  <= '0;
            r_err   <= 1'b0;
         end
         if (w_ar_hs) begin
            r_rdata <= w_rd_oob ? 32'd0 : w_mem_rdata;
            r_rresp <= w_rd_oob ? c_resp_slverr : c_resp_okay;
            r_rlast <= (arlen == 8'd0);
         end
         if (w_w_hs) begin
            r_idx  <= w_idx_nxt;
            r_beat <= r_beat + 8'd1;
            if (w_wlast_bad || w_wr_oob) r_err <= 1'b1;
            if (w_last_beat)
               r_bresp <= (r_err || w_wlast_bad || w_wr_oob) ? c_resp_slverr : c_resp_okay;
         end
         // Next beat is fetched on the accepting edge so bursts stream without bubbles.
         if (w_r_hs) begin
            if (w_last_beat) begin
               r_rlast <= 1'b0;
            end else begin
               r_idx   <= w_idx_nxt;
               r_beat  <= r_beat + 8'd1;
               r_rdata <= w_rd_oob ? 32'd0 : w_mem_rdata;
               r_rresp <= w_rd_oob ? c_resp_slverr : c_resp_okay;
               r_rlast <= ((r_beat + 8'd1) == r_len);
            end
         end
      end
   end

   dmem_array #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_mem (
      .clk    (clk),
      .i_we   (w_we),
      .i_waddr(r_idx[c_aw-1:0]),
      .i_wdata(wdata),
      .i_raddr(w_rd_idx[c_aw-1:0]),
      .o_rdata(w_mem_rdata)
   );

endmodule
`default_nettype wire
